// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: accepts one block, walks the shared round datapath through NR rounds, holds the result.
// Optional macro AES_ROUND_CTRL_DECRYPT_EN adds a decrypt mode (reverse key order, no round constants).
module aes_round_ctrl #(
    parameter int KEY_SIZE = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    input  logic       in_decrypt,
    output logic       dp_decrypt,
`endif
    output logic       busy,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_skip_mix,
    output logic [3:0] dp_key_idx,
    output logic [7:0] dp_rcon,
    output logic       dp_capture
);

    localparam int NR = (KEY_SIZE == 256) ? 14 : (KEY_SIZE == 192) ? 12 : 10;
    localparam logic [3:0] NR4 = 4'(NR);

    generate
        if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
            $error("aes_round_ctrl: KEY_SIZE must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [3:0] rnd_reg;
    logic [7:0] rc_reg;
    logic       round_en_reg;
    logic       skip_mix_reg;
    logic       capture_reg;
    logic [3:0] key_idx_reg;
    logic [7:0] rcon_reg;
    logic       out_valid_reg;
    logic       dec_reg;

    logic       accept;
    logic       req_dec;
    logic [3:0] load_idx;
    logic [3:0] rnd_inc;
    logic [7:0] rc_step;

    // GF(2^8) doubling used by the round-constant chain
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
    endfunction

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    assign req_dec    = in_decrypt;
    assign dp_decrypt = rst_n & dec_reg;
`else
    assign req_dec = 1'b0;
`endif

    assign in_ready = rst_n && (state_reg == IDLE);
    assign accept   = in_valid && in_ready;
    assign load_idx = req_dec ? NR4 : 4'd0;
    assign rnd_inc  = rnd_reg + 4'd1;
    assign rc_step  = xtime(rc_reg);

    // Everything is forced low while reset is held, so no partial result leaks out
    assign busy        = rst_n && (state_reg != IDLE);
    assign dp_load     = accept;
    assign dp_key_idx  = accept ? load_idx : (rst_n ? key_idx_reg : 4'd0);
    assign dp_round_en = rst_n & round_en_reg;
    assign dp_skip_mix = rst_n & skip_mix_reg;
    assign dp_capture  = rst_n & capture_reg;
    assign dp_rcon     = rst_n ? rcon_reg : 8'h00;
    assign out_valid   = rst_n & out_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rnd_reg       <= 4'd0;
            rc_reg        <= 8'h01;
            round_en_reg  <= 1'b0;
            skip_mix_reg  <= 1'b0;
            capture_reg   <= 1'b0;
            key_idx_reg   <= 4'd0;
            rcon_reg      <= 8'h00;
            out_valid_reg <= 1'b0;
            dec_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg    <= ROUND;
                        rnd_reg      <= 4'd1;
                        rc_reg       <= 8'h01;
                        dec_reg      <= req_dec;
                        round_en_reg <= 1'b1;
                        skip_mix_reg <= 1'b0;
                        capture_reg  <= 1'b0;
                        key_idx_reg  <= req_dec ? (NR4 - 4'd1) : 4'd1;
                        rcon_reg     <= req_dec ? 8'h00 : 8'h01;
                    end
                end
                ROUND: begin
                    if (rnd_reg < NR4) begin
                        rnd_reg      <= rnd_inc;
                        rc_reg       <= rc_step;
                        round_en_reg <= 1'b1;
                        // Decrypt walks the key schedule backwards: index = NR - rnd
                        key_idx_reg  <= dec_reg ? (NR4 - rnd_inc) : rnd_inc;
                        rcon_reg     <= dec_reg ? 8'h00 : rc_step;
                        skip_mix_reg <= (rnd_inc == NR4);
                        capture_reg  <= (rnd_inc == NR4);
                    end else begin
                        state_reg     <= DONE;
                        round_en_reg  <= 1'b0;
                        skip_mix_reg  <= 1'b0;
                        capture_reg   <= 1'b0;
                        key_idx_reg   <= 4'd0;
                        rcon_reg      <= 8'h00;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        rnd_reg       <= 4'd0;
                        rc_reg        <= 8'h01;
                        out_valid_reg <= 1'b0;
                        dec_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: 128-bit and 256-bit instances, handshakes, reset, optional decrypt.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, out_ready;
    logic       in_ready, out_valid, busy, dp_load, dp_round_en, dp_skip_mix, dp_capture;
    logic [3:0] dp_key_idx;
    logic [7:0] dp_rcon;

    logic       in_valid2, out_ready2;
    logic       in_ready2, out_valid2, busy2, dp_load2, dp_round_en2, dp_skip_mix2, dp_capture2;
    logic [3:0] dp_key_idx2;
    logic [7:0] dp_rcon2;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    logic in_decrypt, dp_decrypt, in_decrypt2, dp_decrypt2;
`endif

    aes_round_ctrl #(.KEY_SIZE(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        .in_decrypt(in_decrypt), .dp_decrypt(dp_decrypt),
`endif
        .busy(busy), .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_skip_mix(dp_skip_mix),
        .dp_key_idx(dp_key_idx), .dp_rcon(dp_rcon), .dp_capture(dp_capture)
    );

    aes_round_ctrl #(.KEY_SIZE(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        .in_decrypt(in_decrypt2), .dp_decrypt(dp_decrypt2),
`endif
        .busy(busy2), .dp_load(dp_load2), .dp_round_en(dp_round_en2), .dp_skip_mix(dp_skip_mix2),
        .dp_key_idx(dp_key_idx2), .dp_rcon(dp_rcon2), .dp_capture(dp_capture2)
    );

    logic [18:0] outs, outs2;
    assign outs  = {in_ready, out_valid, busy, dp_load, dp_round_en, dp_skip_mix,
                    dp_key_idx, dp_rcon, dp_capture};
    assign outs2 = {in_ready2, out_valid2, busy2, dp_load2, dp_round_en2, dp_skip_mix2,
                    dp_key_idx2, dp_rcon2, dp_capture2};

    logic [7:0] rcon_tbl [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (!busy && !busy2) break;
            step();
        end
        check("drain_idle", {30'd0, busy, busy2}, 32'd0);
    endtask

    int acc1 [8];
    int acc2 [8];
    int n1, n2;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        in_decrypt = 1'b0; in_decrypt2 = 1'b0;
`endif
        step(); step();
        check("reset_outs128", 32'(outs), 32'd0);
        check("reset_outs256", 32'(outs2), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Single encrypt request, consumer always ready
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("accept_load", 32'(dp_load), 32'd1);
        check("accept_key_idx", 32'(dp_key_idx), 32'd0);
        step();
        in_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            #1;
            check($sformatf("r%0d_round_en", r), 32'(dp_round_en), 32'd1);
            check($sformatf("r%0d_key_idx", r), 32'(dp_key_idx), 32'(r));
            check($sformatf("r%0d_rcon", r), 32'(dp_rcon), 32'(rcon_tbl[r-1]));
            check($sformatf("r%0d_skip", r), 32'(dp_skip_mix), 32'(r == 10));
            check($sformatf("r%0d_capture", r), 32'(dp_capture), 32'(r == 10));
            check($sformatf("r%0d_out_valid", r), 32'(out_valid), 32'd0);
            step();
        end
        #1;
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_round_en", 32'(dp_round_en), 32'd0);
        check("done_key_idx", 32'(dp_key_idx), 32'd0);
        step();
        #1;
        check("after_done_out_valid", 32'(out_valid), 32'd0);
        check("after_done_in_ready", 32'(in_ready), 32'd1);
        check("after_done_busy", 32'(busy), 32'd0);

        // Backpressure, with in_valid held high through ROUND and DONE
        out_ready = 1'b0; in_valid = 1'b1;
        #1;
        check("bp_accept_load", 32'(dp_load), 32'd1);
        step();
        for (int r = 1; r <= 10; r++) begin
            #1;
            check($sformatf("bp_r%0d_no_load", r), 32'(dp_load), 32'd0);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_no_load", k), 32'(dp_load), 32'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_release_no_load", 32'(dp_load), 32'd0);
        step();
        #1;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);

        // out_ready pulses in IDLE must not create a result
        step(); step();
        check("idle_out_ready_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_ready_busy", 32'(busy), 32'd0);

        // Back-to-back on both key sizes
        in_valid = 1'b1; out_ready = 1'b1; in_valid2 = 1'b1; out_ready2 = 1'b1;
        n1 = 0; n2 = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dp_load && n1 < 8) begin acc1[n1] = c; n1++; end
            if (dp_load2 && n2 < 8) begin acc2[n2] = c; n2++; end
            if (c >= 1 && c <= 14) begin
                check($sformatf("k256_r%0d_key_idx", c), 32'(dp_key_idx2), 32'(c));
                check($sformatf("k256_r%0d_rcon", c), 32'(dp_rcon2), 32'(rcon_tbl[c-1]));
                check($sformatf("k256_r%0d_skip", c), 32'(dp_skip_mix2), 32'(c == 14));
            end
            if (c == 15) check("k256_out_valid", 32'(out_valid2), 32'd1);
            step();
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
        check("b2b128_accepts", 32'(n1), 32'd4);
        check("b2b256_accepts", 32'(n2), 32'd3);
        if (n1 >= 2) check("b2b128_spacing", 32'(acc1[1] - acc1[0]), 32'd12);
        if (n1 >= 3) check("b2b128_spacing2", 32'(acc1[2] - acc1[1]), 32'd12);
        if (n2 >= 2) check("b2b256_spacing", 32'(acc2[1] - acc2[0]), 32'd16);
        drain();

        // Reset in the 4th ROUND cycle
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        #1;
        check("mid_key_idx_before_reset", 32'(dp_key_idx), 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_reset_low_outs", 32'(outs), 32'd0);
        step();
        #1;
        check("mid_reset_edge_outs", 32'(outs), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_release_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        #1;
        check("restart_load", 32'(dp_load), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("restart_key_idx", 32'(dp_key_idx), 32'd1);
        check("restart_rcon", 32'(dp_rcon), 32'h01);
        check("restart_round_en", 32'(dp_round_en), 32'd1);
        drain();

`ifdef AES_ROUND_CTRL_DECRYPT_EN
        // Decrypt: mode captured at accept, keys walked 9..0
        in_decrypt = 1'b1; in_valid = 1'b1;
        #1;
        check("dec_load", 32'(dp_load), 32'd1);
        check("dec_load_idx", 32'(dp_key_idx), 32'd10);
        step();
        in_valid = 1'b0; in_decrypt = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            #1;
            check($sformatf("dec_r%0d_key_idx", r), 32'(dp_key_idx), 32'(10 - r));
            check($sformatf("dec_r%0d_rcon", r), 32'(dp_rcon), 32'd0);
            check($sformatf("dec_r%0d_skip", r), 32'(dp_skip_mix), 32'(r == 10));
            check($sformatf("dec_r%0d_capture", r), 32'(dp_capture), 32'(r == 10));
            check($sformatf("dec_r%0d_mode", r), 32'(dp_decrypt), 32'd1);
            step();
        end
        #1;
        check("dec_done_out_valid", 32'(out_valid), 32'd1);
        check("dec_done_mode", 32'(dp_decrypt), 32'd1);
        step();
        #1;
        check("dec_idle_mode", 32'(dp_decrypt), 32'd0);
        check("dec_idle_busy", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
